// File: rtl/muxn_scan_reg.sv
// muxn_scan_reg: registered N:1 mux whose select is either loaded (MANUAL) or stepped by a dwell counter (SCAN).
// Defining MUXN_SCAN_REG_PARITY_EN adds a registered even-parity output out_parity.
module muxn_scan_reg #(
    parameter int N = 8,
    parameter int WIDTH = 1,
    parameter int DWELL = 1,
    localparam int SW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SW-1:0]      sel,
    input  logic               sel_load,
    input  logic               scan_start,
    input  logic               scan_stop,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic [SW-1:0]      cur_sel,
    output logic               wrap,
    output logic               sel_err
`ifdef MUXN_SCAN_REG_PARITY_EN
    ,
    output logic               out_parity
`endif
);
    localparam logic [0:0] MANUAL = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;
    localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;

    logic [0:0]       state_q, state_d;
    logic [SW-1:0]    cur_sel_q, cur_sel_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q, wrap_q, wrap_d, sel_err_q, sel_err_d;
    logic             dwell_end, last_ch, sel_bad;
    logic [WIDTH-1:0] ch [N];

    for (genvar k = 0; k < N; k++) begin : g_ch
        assign ch[k] = in_data[k*WIDTH +: WIDTH];
    end

    assign dwell_end = dwell_q == DW'(DWELL - 1);
    assign last_ch   = cur_sel_q == SW'(N - 1);
    assign sel_bad   = 32'(sel) >= N;

    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        dwell_d   = dwell_q;
        wrap_d    = 1'b0;
        sel_err_d = 1'b0;
        if (sel_load) begin
            state_d   = MANUAL;
            dwell_d   = '0;
            sel_err_d = sel_bad;
            cur_sel_d = sel_bad ? cur_sel_q : sel;
        end else if (scan_stop) begin
            state_d = MANUAL;
            dwell_d = '0;
        end else if (scan_start) begin
            state_d   = SCAN;
            cur_sel_d = '0;
            dwell_d   = '0;
        end else if (state_q == SCAN) begin
            dwell_d = dwell_end ? '0 : dwell_q + 1'b1;
            if (dwell_end) begin
                cur_sel_d = last_ch ? '0 : cur_sel_q + 1'b1;
                wrap_d    = last_ch;
            end
        end
    end

    // out_valid drops in the cycle cur_sel moves, while out_data still shows the old channel
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MANUAL;
            cur_sel_q   <= '0;
            dwell_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_sel_q   <= cur_sel_d;
            dwell_q     <= dwell_d;
            out_data_q  <= ch[cur_sel_q];
            out_valid_q <= cur_sel_d == cur_sel_q;
            wrap_q      <= wrap_d;
            sel_err_q   <= sel_err_d;
        end
    end

`ifdef MUXN_SCAN_REG_PARITY_EN
    logic out_parity_q;
    always_ff @(posedge clk) begin
        if (rst) out_parity_q <= 1'b0;
        else out_parity_q <= ^ch[cur_sel_q];
    end
    assign out_parity = out_parity_q;
`endif

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign cur_sel   = cur_sel_q;
    assign wrap      = wrap_q;
    assign sel_err   = sel_err_q;
endmodule

// File: tb/tb_muxn_scan_reg.sv
// tb_muxn_scan_reg: scoreboard bench driving an N=8/DWELL=3/WIDTH=4 and an N=5/DWELL=1/WIDTH=1 instance in lockstep.
module tb_muxn_scan_reg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, sel_load = 1'b0, scan_start = 1'b0, scan_stop = 1'b0;
    logic [2:0] sel = '0;
    logic [31:0] in_a = '0;
    logic [4:0] in_b = '0;
    logic [3:0] a_out_data;
    logic [2:0] a_cur_sel, b_cur_sel;
    logic [0:0] b_out_data;
    logic a_out_valid, a_wrap, a_sel_err, b_out_valid, b_wrap, b_sel_err;
    logic [7:0] pat = 8'b10010110;

    typedef struct {
        int sel;
        int data;
        int valid;
        int wrap;
        int err;
    } exp_t;

    exp_t qa[$], qb[$];
    int n_vec = 0, n_err = 0, wa = 0, wb = 0;
    int ms[2] = '{0, 0}, mc[2] = '{0, 0}, mq[2] = '{0, 0};
    int nn[2] = '{8, 5}, dd[2] = '{3, 1};

`ifdef MUXN_SCAN_REG_PARITY_EN
    logic a_out_parity, b_out_parity;
`endif

    muxn_scan_reg #(.N(8), .WIDTH(4), .DWELL(3)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_a), .sel(sel), .sel_load(sel_load),
        .scan_start(scan_start), .scan_stop(scan_stop), .out_data(a_out_data),
        .out_valid(a_out_valid), .cur_sel(a_cur_sel), .wrap(a_wrap), .sel_err(a_sel_err)
`ifdef MUXN_SCAN_REG_PARITY_EN
        , .out_parity(a_out_parity)
`endif
    );

    muxn_scan_reg #(.N(5), .WIDTH(1), .DWELL(1)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_b), .sel(sel), .sel_load(sel_load),
        .scan_start(scan_start), .scan_stop(scan_stop), .out_data(b_out_data),
        .out_valid(b_out_valid), .cur_sel(b_cur_sel), .wrap(b_wrap), .sel_err(b_sel_err)
`ifdef MUXN_SCAN_REG_PARITY_EN
        , .out_parity(b_out_parity)
`endif
    );

    function automatic int chan(input int d, input int k);
        return d == 0 ? int'(in_a[k*4 +: 4]) : int'(in_b[k]);
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference: what each instance must show after the coming edge, given the inputs now applied
    task automatic model(input int d, output exp_t e);
        int ns, nc, nsc;
        bit bad;
        bad = sel_load && int'(sel) >= nn[d];
        ns = mq[d]; nc = mc[d]; nsc = ms[d];
        e.wrap = 0; e.err = 0;
        if (rst) begin
            ns = 0; nc = 0; nsc = 0; e.data = 0; e.valid = 0;
        end else begin
            e.data = chan(d, mq[d]);
            e.err = int'(bad);
            if (sel_load) begin
                nsc = 0; nc = 0;
                if (!bad) ns = int'(sel);
            end else if (scan_stop) begin
                nsc = 0; nc = 0;
            end else if (scan_start) begin
                nsc = 1; nc = 0; ns = 0;
            end else if (nsc == 1) begin
                if (nc == dd[d] - 1) begin
                    nc = 0;
                    ns = (ns == nn[d] - 1) ? 0 : ns + 1;
                    e.wrap = int'(ns == 0);
                end else nc++;
            end
            e.valid = int'(ns == mq[d]);
        end
        e.sel = ns;
        mq[d] = ns; mc[d] = nc; ms[d] = nsc;
    endtask

    task automatic tick();
        exp_t ea, eb;
        model(0, ea);
        model(1, eb);
        qa.push_back(ea);
        qb.push_back(eb);
        @(posedge clk);
        #1;
        ea = qa.pop_front();
        eb = qb.pop_front();
        check("a_sel", int'(a_cur_sel), ea.sel);
        check("a_data", int'(a_out_data), ea.data);
        check("a_valid", int'(a_out_valid), ea.valid);
        check("a_wrap", int'(a_wrap), ea.wrap);
        check("a_err", int'(a_sel_err), ea.err);
        check("b_sel", int'(b_cur_sel), eb.sel);
        check("b_data", int'(b_out_data), eb.data);
        check("b_valid", int'(b_out_valid), eb.valid);
        check("b_wrap", int'(b_wrap), eb.wrap);
        check("b_err", int'(b_sel_err), eb.err);
`ifdef MUXN_SCAN_REG_PARITY_EN
        check("a_par", int'(a_out_parity), int'(^ea.data));
        check("b_par", int'(b_out_parity), int'(^eb.data));
`endif
        if (a_wrap) wa++;
        if (b_wrap) wb++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int k = 0; k < 8; k++) in_a[k*4 +: 4] = {3'b000, pat[k]};
        in_a[11:8] = 4'b1011;
        in_b = 5'b10110;
        ticks(2);
        rst = 1'b0;
        ticks(2);
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            sel_load = 1'b1;
            tick();
            sel_load = 1'b0;
            ticks(2);
            check("sweep", int'(a_out_data[0]), int'(pat[s]));
            if (s == 2) check("ch2", int'(a_out_data), 11);
        end
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        wa = 0;
        wb = 0;
        ticks(48);
        check("wraps_a", wa, 2);
        check("wraps_b", wb, 9);
        sel = 3'd6;
        sel_load = 1'b1;
        scan_start = 1'b1;
        tick();
        sel_load = 1'b0;
        scan_start = 1'b0;
        ticks(2);
        scan_start = 1'b1;
        scan_stop = 1'b1;
        tick();
        scan_start = 1'b0;
        scan_stop = 1'b0;
        ticks(3);
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        ticks(7);
        scan_stop = 1'b1;
        tick();
        scan_stop = 1'b0;
        ticks(4);
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        ticks(5);
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        ticks(4);
        check("pre_rst_b", int'(b_cur_sel), 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ticks(3);
        sel = 3'd3;
        sel_load = 1'b1;
        tick();
        sel_load = 1'b0;
        ticks(2);
        in_a[15:12] = 4'b0110;
        in_b = 5'b00001;
        ticks(3);
        sel = 3'd5;
        sel_load = 1'b1;
        tick();
        sel = 3'd7;
        tick();
        sel_load = 1'b0;
        ticks(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
